// File: rtl/dmem_access_unit_if.sv
// Bundles the memory-stage pipeline signals and the data-memory bus of
// dmem_access_unit into one interface.
//   master : the access unit itself. It receives the instruction fields and
//            the memory response, and drives stall, the memory request and
//            the completion pulses.
//   slave  : the surrounding pipeline and memory. This is the opposite view.
interface dmem_access_unit_if;
  // Pipeline side: instruction presented to the memory stage
  logic        in_valid;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr;
  logic [31:0] in_rs2;
  logic        stall;
  // Data-memory bus
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  // Result and status toward writeback
  logic [31:0] dmem_out;
  logic        out_valid;
  logic        misaligned;
  logic        bus_error;

  modport master (
    input  in_valid, in_opcode, in_funct3, in_addr, in_rs2,
    input  mem_ack, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output dmem_out, out_valid, misaligned, bus_error
  );

  modport slave (
    output in_valid, in_opcode, in_funct3, in_addr, in_rs2,
    output mem_ack, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  dmem_out, out_valid, misaligned, bus_error
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit. It accepts an aligned LOAD or STORE while
// idle and issues one data-memory request. The request is held stable until
// mem_ack arrives or the request times out. On completion the unit returns
// the load data, shifted so that the addressed byte sits in bits [7:0].
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : dmem_access_unit_if.master. It carries the instruction
//              (in_*), stall, the memory bus (mem_*), dmem_out and the
//              one-cycle pulses out_valid, misaligned and bus_error.
// Parameter:
//   TIMEOUT  : number of REQ cycles without mem_ack before the request is
//              aborted.
module dmem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_unit_if.master bus
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Byte enables for a store. The lane shift comes from the low address bits.
  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] off);
    case (f3)
      3'b000:  store_strb = 4'b0001 << off;
      3'b001:  store_strb = 4'b0011 << off;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across all lanes, so the strobes alone select
  // the bytes that are written.
  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] rs2);
    case (f3)
      3'b000:  store_data = {4{rs2[7:0]}};
      3'b001:  store_data = {2{rs2[15:0]}};
      default: store_data = rs2;
    endcase
  endfunction

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       off_q, off_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_wstrb_q, mem_wstrb_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [31:0]      dmem_out_q, dmem_out_d;
  logic             out_valid_q, out_valid_d;
  logic             misaligned_q, misaligned_d;
  logic             bus_error_q, bus_error_d;

  logic is_store;
  logic is_mem;
  logic aligned;
  logic accept;
  logic reject;

  always_comb begin
    is_store = (bus.in_opcode == OP_STORE);
    is_mem   = (bus.in_opcode == OP_LOAD) || is_store;
    // funct3[1:0] encodes the access size (00 byte, 01 half, other word).
    // Bit 2 only selects load sign extension, which this unit does not apply.
    case (bus.in_funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.in_addr[0];
      default: aligned = (bus.in_addr[1:0] == 2'b00);
    endcase
    accept = (state_q == ST_IDLE) && bus.in_valid && is_mem && aligned;
    reject = (state_q == ST_IDLE) && bus.in_valid && is_mem && !aligned;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_wdata_d  = mem_wdata_q;
    dmem_out_d   = dmem_out_q;
    out_valid_d  = 1'b0;
    misaligned_d = 1'b0;
    bus_error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_REQ;
          cnt_d       = '0;
          off_d       = bus.in_addr[1:0];
          mem_req_d   = 1'b1;
          mem_we_d    = is_store;
          mem_addr_d  = {bus.in_addr[31:2], 2'b00};
          mem_wstrb_d = is_store ? store_strb(bus.in_funct3, bus.in_addr[1:0]) : 4'b0000;
          mem_wdata_d = is_store ? store_data(bus.in_funct3, bus.in_rs2) : 32'h0;
        end else if (reject) begin
          misaligned_d = 1'b1;
        end
      end
      default: begin
        // If the ack and the timeout fall in the same cycle, the ack wins.
        if (bus.mem_ack) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          if (!mem_we_q) begin
            dmem_out_d = bus.mem_rdata >> {off_q, 3'b000};
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_IDLE;
          mem_req_d   = 1'b0;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      off_q        <= 2'b00;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wstrb_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      dmem_out_q   <= 32'h0;
      out_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_wdata_q  <= mem_wdata_d;
      dmem_out_q   <= dmem_out_d;
      out_valid_q  <= out_valid_d;
      misaligned_q <= misaligned_d;
      bus_error_q  <= bus_error_d;
    end
  end

  // The pipeline is held while a request is being accepted and while it
  // waits for the ack. It is released in the ack cycle, so the same
  // instruction is not accepted a second time.
  assign bus.stall      = accept || ((state_q == ST_REQ) && !bus.mem_ack);
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.dmem_out   = dmem_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.misaligned = misaligned_q;
  assign bus.bus_error  = bus_error_q;
endmodule

// File: tb/tb_dmem_access_unit.sv
// Testbench for dmem_access_unit, instantiated with TIMEOUT = 4. A
// behavioural model derives the expected bus fields, pulses and load result
// for each transaction from access size, byte offset and ack delay.
module tb_dmem_access_unit;
  localparam int TMO = 4;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_dout = 32'h0;

  dmem_access_unit_if bus_if ();

  dmem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus_if.in_valid  = 1'b0;
    bus_if.in_opcode = 7'h0;
    bus_if.in_funct3 = 3'h0;
    bus_if.in_addr   = 32'h0;
    bus_if.in_rs2    = 32'h0;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = 32'h0;
  endtask

  // Runs one instruction through the unit. delay is the number of REQ
  // cycles that pass without an ack. stall_hi returns the number of
  // stalled cycles.
  task automatic run_txn(input string name, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int delay, output int stall_hi);
    logic        is_mem, is_store, ok, done_ok, timed;
    int          n, nb, off;
    logic [3:0]  e_strb;
    logic [31:0] e_addr, e_wdata;
    logic [69:0] e_bus, a_bus;
    is_mem   = (op == LOAD) || (op == STORE);
    is_store = (op == STORE);
    n        = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off      = int'(addr[1:0]);
    ok       = (off % n) == 0;
    e_addr   = addr - 32'(off);
    e_strb   = 4'b0000;
    e_wdata  = 32'h0;
    if (is_store) begin
      nb = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
      for (int b = 0; b < 4; b++) begin
        if (nb == 4) begin
          e_strb[b] = 1'b1;
          e_wdata[8*b +: 8] = rs2[8*b +: 8];
        end else begin
          e_strb[b] = (b >= off) && (b < off + nb);
          e_wdata[8*b +: 8] = rs2[8*(b % nb) +: 8];
        end
      end
    end
    e_bus = {1'b1, is_store, e_addr, e_strb, e_wdata};
    stall_hi = 0;

    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.in_opcode = op;
    bus_if.in_funct3 = f3;
    bus_if.in_addr   = addr;
    bus_if.in_rs2    = rs2;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = $urandom;
    #1;
    checks++;
    if (bus_if.stall !== (is_mem && ok)) begin
      errors++;
      $display("FAIL %s accept_stall got %0b want %0b", name, bus_if.stall, is_mem && ok);
    end
    if (bus_if.stall === 1'b1) stall_hi++;

    if (!(is_mem && ok)) begin
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      #1;
      checks++;
      if ({bus_if.mem_req, bus_if.misaligned, bus_if.out_valid, bus_if.bus_error, bus_if.stall} !==
          {1'b0, is_mem, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL %s reject {req,mis,ov,berr,stall} got %b want %b", name,
                 {bus_if.mem_req, bus_if.misaligned, bus_if.out_valid, bus_if.bus_error, bus_if.stall},
                 {1'b0, is_mem, 3'b000});
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus_if.mem_req, bus_if.misaligned, bus_if.out_valid, bus_if.bus_error} !== 4'b0000) begin
        errors++;
        $display("FAIL %s reject_after pulses got %b want 0000", name,
                 {bus_if.mem_req, bus_if.misaligned, bus_if.out_valid, bus_if.bus_error});
      end
      return;
    end

    done_ok = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);
      a_bus = {bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wstrb, bus_if.mem_wdata};
      checks++;
      if (a_bus !== e_bus) begin
        errors++;
        $display("FAIL %s req_bus cyc %0d got %h want %h", name, k, a_bus, e_bus);
      end
      bus_if.mem_ack   = (k == delay);
      bus_if.mem_rdata = (k == delay) ? rdata : $urandom;
      #1;
      checks++;
      if (bus_if.stall !== !bus_if.mem_ack) begin
        errors++;
        $display("FAIL %s req_stall cyc %0d got %0b want %0b", name, k, bus_if.stall, !bus_if.mem_ack);
      end
      if (bus_if.stall === 1'b1) stall_hi++;
      if (k == delay) begin
        done_ok = 1'b1;
        break;
      end
    end
    timed = !done_ok;

    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.mem_ack  = 1'b0;
    #1;
    if (done_ok && !is_store) exp_dout = rdata >> (8 * off);
    checks++;
    if ({bus_if.out_valid, bus_if.bus_error, bus_if.mem_req, bus_if.misaligned, bus_if.stall} !==
        {done_ok, timed, 3'b000}) begin
      errors++;
      $display("FAIL %s end {ov,berr,req,mis,stall} got %b want %b", name,
               {bus_if.out_valid, bus_if.bus_error, bus_if.mem_req, bus_if.misaligned, bus_if.stall},
               {done_ok, timed, 3'b000});
    end
    checks++;
    if (bus_if.dmem_out !== exp_dout) begin
      errors++;
      $display("FAIL %s dmem_out got %h want %h", name, bus_if.dmem_out, exp_dout);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus_if.out_valid, bus_if.bus_error, bus_if.mem_req} !== 3'b000) begin
      errors++;
      $display("FAIL %s pulse_width {ov,berr,req} got %b want 000", name,
               {bus_if.out_valid, bus_if.bus_error, bus_if.mem_req});
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({bus_if.stall, bus_if.mem_req, bus_if.mem_we, bus_if.out_valid, bus_if.misaligned,
         bus_if.bus_error, bus_if.mem_addr, bus_if.mem_wstrb, bus_if.mem_wdata, bus_if.dmem_out} !== '0) begin
      errors++;
      $display("FAIL reset outputs got req=%0b addr=%h strb=%b wdata=%h dout=%h want all zero",
               bus_if.mem_req, bus_if.mem_addr, bus_if.mem_wstrb, bus_if.mem_wdata, bus_if.dmem_out);
    end
    rst = 1'b0;
    exp_dout = 32'h0;
  endtask

  task automatic test_store_sb();
    int sh;
    run_txn("sb_1003", STORE, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 2, sh);
    checks++;
    if (sh != 3) begin
      errors++;
      $display("FAIL sb_stall_cycles got %0d want 3", sh);
    end
  endtask

  task automatic test_load_lbu();
    int sh;
    run_txn("lbu_2002", LOAD, 3'b100, 32'h0000_2002, 32'h0, 32'h1122_3344, 0, sh);
    checks++;
    if (bus_if.dmem_out !== 32'h0000_1122) begin
      errors++;
      $display("FAIL lbu_result got %h want 00001122", bus_if.dmem_out);
    end
  endtask

  task automatic test_misaligned();
    int sh;
    run_txn("lw_2001", LOAD, 3'b010, 32'h0000_2001, 32'h0, 32'h0, 0, sh);
    run_txn("sh_0005", STORE, 3'b001, 32'h0000_0005, 32'h1234_5678, 32'h0, 0, sh);
  endtask

  task automatic test_timeout();
    int sh;
    run_txn("sw_3000_tmo", STORE, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 32'h0, 100, sh);
    checks++;
    if (sh != TMO + 1) begin
      errors++;
      $display("FAIL tmo_stall_cycles got %0d want %0d", sh, TMO + 1);
    end
    run_txn("lw_ack_at_tmo", LOAD, 3'b010, 32'h0000_3004, 32'h0, 32'h5566_7788, TMO - 1, sh);
  endtask

  task automatic test_reset_in_req();
    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.in_opcode = LOAD;
    bus_if.in_funct3 = 3'b001;
    bus_if.in_addr   = 32'h0000_4002;
    bus_if.mem_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = 32'hDEAD_BEEF;
    exp_dout = 32'h0;
    #1;
    checks++;
    if ({bus_if.mem_req, bus_if.out_valid, bus_if.stall, bus_if.dmem_out} !== 35'h0) begin
      errors++;
      $display("FAIL rst_in_req req=%0b ov=%0b stall=%0b dout=%h want 0 0 0 0",
               bus_if.mem_req, bus_if.out_valid, bus_if.stall, bus_if.dmem_out);
    end
    @(negedge clk);
    bus_if.mem_ack = 1'b0;
    #1;
    checks++;
    if ({bus_if.mem_req, bus_if.out_valid, bus_if.bus_error, bus_if.dmem_out} !== 35'h0) begin
      errors++;
      $display("FAIL late_ack req=%0b ov=%0b berr=%0b dout=%h want all 0",
               bus_if.mem_req, bus_if.out_valid, bus_if.bus_error, bus_if.dmem_out);
    end
  endtask

  task automatic test_non_mem_and_idle_ack();
    int sh;
    run_txn("alu_op", 7'b0110011, 3'b000, 32'h0000_0100, 32'h0, 32'h0, 0, sh);
    @(negedge clk);
    bus_if.mem_ack   = 1'b1;
    bus_if.mem_rdata = 32'h8765_4321;
    @(negedge clk);
    bus_if.mem_ack = 1'b0;
    #1;
    checks++;
    if ({bus_if.out_valid, bus_if.mem_req, bus_if.bus_error} !== 3'b000 || bus_if.dmem_out !== exp_dout) begin
      errors++;
      $display("FAIL idle_ack ov=%0b req=%0b berr=%0b dout=%h want 0 0 0 %h",
               bus_if.out_valid, bus_if.mem_req, bus_if.bus_error, bus_if.dmem_out, exp_dout);
    end
  endtask

  task automatic test_random();
    int          sh, sel;
    logic [6:0]  op;
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 4);
      op  = (sel < 2) ? LOAD : (sel < 4) ? STORE : 7'($urandom);
      run_txn($sformatf("rand%0d", i), op, 3'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, TMO + 1), sh);
    end
  endtask

  task automatic test_back_to_back();
    int sh;
    run_txn("b2b_sw", STORE, 3'b010, 32'h0000_5000, 32'h0102_0304, 32'h0, 0, sh);
    run_txn("b2b_lh", LOAD, 3'b101, 32'h0000_5002, 32'h0, 32'hA1B2_C3D4, 1, sh);
    run_txn("b2b_sh", STORE, 3'b001, 32'h0000_5002, 32'h0000_BEEF, 32'h0, 0, sh);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_store_sb();
    test_load_lbu();
    test_misaligned();
    test_timeout();
    test_reset_in_req();
    test_non_mem_and_idle_ack();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles a request waits for mem_ack before abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  memory-stage instruction present.
REQ-005 in_opcode  input  7  instruction opcode; LOAD = 0000011, STORE = 0100011.
REQ-006 in_funct3  input  3  access width/sign selector.
REQ-007 in_addr  input  32  effective byte address (ALU result).
REQ-008 in_rs2  input  32  store source data.
REQ-009 stall  output  1  pipeline hold request.
REQ-010 mem_req  output  1  data-memory request valid.
REQ-011 mem_we  output  1  1 = write, 0 = read.
REQ-012 mem_addr  output  32  word-aligned address.
REQ-013 mem_wstrb  output  4  byte write enables.
REQ-014 mem_wdata  output  32  lane-positioned write data.
REQ-015 mem_ack  input  1  memory completion; read data valid in the same cycle.
REQ-016 mem_rdata  input  32  raw memory word.
REQ-017 dmem_out  output  32  load word shifted right so the addressed byte sits in bits [7:0]; consumed by writeback.
REQ-018 out_valid  output  1  one-cycle pulse: access completed.
REQ-019 misaligned  output  1  one-cycle pulse: access rejected for alignment.
REQ-020 bus_error  output  1  one-cycle pulse: request timed out.

Function
REQ-021 FSM states: IDLE, REQ; accept is allowed only in IDLE.
REQ-022 Accept: IDLE, in_valid = 1, opcode LOAD/STORE, aligned -> register request fields; next cycle REQ with mem_req = 1.
REQ-023 Alignment: byte always aligned; halfword (funct3[1:0] = 01) requires addr[0] = 0; word (all other funct3) requires addr[1:0] = 00.
REQ-024 Misaligned accept: no request; misaligned = 1 the next cycle; stay in IDLE; out_valid stays 0.
REQ-025 Non-memory opcode or in_valid = 0: no action; stall = 0.
REQ-026 mem_addr = {in_addr[31:2], 2'b00}; mem_we = 1 for STORE.
REQ-027 Store SB (000): wstrb = 0001 << addr[1:0]; wdata = rs2[7:0] replicated four times.
REQ-028 Store SH (001): wstrb = 0011 << addr[1:0]; wdata = rs2[15:0] replicated twice.
REQ-029 Store SW (010) and any other funct3: wstrb = 1111; wdata = rs2.
REQ-030 Load: mem_wstrb = 0000; mem_wdata = 0.
REQ-031 mem_req, mem_we, mem_addr, mem_wstrb, and mem_wdata are held stable throughout REQ.
REQ-032 REQ with mem_ack = 1: mem_req drops on the next cycle; state returns to IDLE; out_valid = 1 for one cycle.
REQ-033 Load completion: dmem_out <= mem_rdata >> (8*addr[1:0]), zero-filled, registered in the ack cycle; dmem_out holds until the next load completes.
REQ-034 Timeout counter: cleared on accept; increments each REQ cycle without ack; when it reaches TIMEOUT-1 without ack -> abort to IDLE, bus_error = 1 for one cycle, out_valid = 0, dmem_out unchanged.
REQ-035 mem_ack and timeout in the same cycle: ack wins; no bus_error.
REQ-036 stall = (IDLE and a valid aligned LOAD/STORE at the inputs) or (REQ and mem_ack = 0); stall is combinational.
REQ-037 mem_ack in IDLE is ignored.
REQ-038 Inputs are ignored while in REQ; the held pipeline presents the same instruction, which is not re-accepted in the out_valid cycle because stall = 0 then lets the pipeline advance.

Reset
REQ-039 rst = 1: state IDLE; counter 0; mem_req, mem_we, stall, out_valid, misaligned, bus_error = 0; mem_addr, mem_wstrb, mem_wdata, dmem_out = 0.
REQ-040 Reset during REQ: mem_req = 0 the cycle after reset is sampled; a late mem_ack is ignored.

Verification
REQ-041 SB, addr 0x1003, rs2 0xAABBCCDD, ack after 2 cycles -> mem_addr 0x1000, wstrb 1000, wdata 0xDDDDDDDD, stall high 3 cycles, one out_valid pulse.
REQ-042 LBU, addr 0x2002, mem_rdata 0x11223344 -> dmem_out 0x00001122, out_valid pulse, mem_we 0, wstrb 0000.
REQ-043 LW, addr 0x2001 -> misaligned pulse, no mem_req, stall 0, out_valid 0.
REQ-044 SW, addr 0x3000, no ack, TIMEOUT 4 -> mem_req high 4 cycles, then bus_error pulse, state IDLE.
REQ-045 LH, addr 0x4002, rst asserted in the second REQ cycle, ack one cycle later -> mem_req 0 after reset, no out_valid, dmem_out 0.
REQ-046 Non-memory opcode 0110011 with in_valid = 1 -> stall 0, mem_req 0, all pulses 0.
